// File: rtl/ptcalc_mul_arb_pkg.sv
// Shared constants, FSM state and requester-index type for the multiplier arbiter.
package ptcalc_mul_arb_pkg;

  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned NUM_STAGE_DEF = 3;
  localparam int unsigned DIN_W_DEF     = 15;
  localparam int unsigned DOUT_W_DEF    = 30;
  localparam int unsigned REQ_IDX_W     = 3;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Round-robin successor of a requester index, wrapping at nreq.
  function automatic req_idx_t next_idx(input req_idx_t idx, input int unsigned nreq);
    if (32'(idx) + 32'd1 >= nreq) return '0;
    return idx + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/ptcalc_mul_arb_rr.sv
// Combinational round-robin pick: lowest requester at or above the pointer,
// otherwise the lowest requester overall (wrap-around).
module ptcalc_mul_arb_rr
  import ptcalc_mul_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] i_req,
  input  req_idx_t        i_ptr,
  output logic [NREQ-1:0] o_gnt
);

  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_sel;

  always_comb begin
    w_mask = ~((NREQ'(1) << i_ptr) - NREQ'(1));
    w_hi   = i_req & w_mask;
    w_sel  = (|w_hi) ? w_hi : i_req;
    // Isolate the lowest set bit.
    o_gnt  = w_sel & (~w_sel + NREQ'(1));
  end

endmodule

// File: rtl/ptcalc_mul_arbiter.sv
// Round-robin arbiter with lock sharing one pipelined signed multiplier among NREQ requesters.
// Optional accept counters are enabled by defining PTCALC_MUL_ARB_STATS_EN.
module ptcalc_mul_arbiter
  import ptcalc_mul_arb_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEF,
  parameter int unsigned NUM_STAGE = NUM_STAGE_DEF,
  parameter int unsigned DIN_W     = DIN_W_DEF,
  parameter int unsigned DOUT_W    = DOUT_W_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ*DIN_W-1:0] req_a,
  input  logic [NREQ*DIN_W-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [DOUT_W-1:0]     rsp_p,
  output logic                  busy
`ifdef PTCALC_MUL_ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [NREQ*16-1:0]    stat_grants
`endif
);

  arb_state_e r_state;
  req_idx_t   r_rr_ptr;
  req_idx_t   r_owner;

  logic [NREQ-1:0]   r_tag [NUM_STAGE];
  logic [DOUT_W-1:0] r_p   [NUM_STAGE];

  logic [NREQ-1:0]          w_gnt;
  logic [NREQ-1:0]          w_owner_mask;
  logic                     w_acc;
  logic                     w_lock_acc;
  req_idx_t                 w_idx;
  logic [DIN_W-1:0]         w_a;
  logic [DIN_W-1:0]         w_b;
  logic signed [DOUT_W-1:0] w_ax;
  logic signed [DOUT_W-1:0] w_bx;
  logic signed [DOUT_W-1:0] w_prod;
  logic                     w_inflight;

  ptcalc_mul_arb_rr #(.NREQ(NREQ)) u_rr (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt)
  );

  // Ready is forced low while reset is asserted; otherwise only the owner may go in LOCKED.
  always_comb begin
    w_owner_mask = NREQ'(1) << r_owner;
    req_ready    = '0;
    if (!ap_rst) begin
      if (r_state == LOCKED) req_ready = req_valid & w_owner_mask;
      else                   req_ready = w_gnt;
    end
    w_acc      = |req_ready;
    w_lock_acc = |(req_lock & req_ready);
  end

  always_comb begin
    w_idx = '0;
    w_a   = '0;
    w_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        w_idx = req_idx_t'(i);
        w_a   = req_a[i*DIN_W +: DIN_W];
        w_b   = req_b[i*DIN_W +: DIN_W];
      end
    end
    // Sign-extend to full product width so the multiply keeps every bit.
    w_ax   = {{(DOUT_W-DIN_W){w_a[DIN_W-1]}}, w_a};
    w_bx   = {{(DOUT_W-DIN_W){w_b[DIN_W-1]}}, w_b};
    w_prod = w_ax * w_bx;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state  <= ARB;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_acc) begin
            if (w_lock_acc) begin
              r_state <= LOCKED;
              r_owner <= w_idx;
            end else begin
              r_rr_ptr <= next_idx(w_idx, NREQ);
            end
          end
        end
        LOCKED: begin
          // Leave on an unlocked owner accept or when the owner drops valid.
          if (!w_acc || !w_lock_acc) begin
            r_state  <= ARB;
            r_rr_ptr <= next_idx(r_owner, NREQ);
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  // Product/tag delay line; the last stage drives the response outputs.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int s = 0; s < NUM_STAGE; s++) begin
        r_tag[s] <= '0;
        r_p[s]   <= '0;
      end
    end else begin
      r_tag[0] <= req_ready;
      if (w_acc) r_p[0] <= w_prod;
      for (int s = 1; s < NUM_STAGE; s++) begin
        r_tag[s] <= r_tag[s-1];
        r_p[s]   <= r_p[s-1];
      end
    end
  end

  always_comb begin
    w_inflight = 1'b0;
    for (int s = 0; s < NUM_STAGE; s++) w_inflight = w_inflight | (|r_tag[s]);
    busy      = w_inflight | (r_state == LOCKED);
    rsp_valid = r_tag[NUM_STAGE-1];
    rsp_p     = r_p[NUM_STAGE-1];
  end

`ifdef PTCALC_MUL_ARB_STATS_EN
  logic [15:0] r_cnt [NREQ];

  // Saturating per-requester accept counters; clear has priority.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (stat_clr)                                 r_cnt[i] <= '0;
        else if (req_ready[i] && r_cnt[i] != 16'hFFFF) r_cnt[i] <= r_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) stat_grants[i*16 +: 16] = r_cnt[i];
  end
`endif

endmodule

// File: tb/tb_ptcalc_mul_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_ptcalc_mul_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned NS = 3;
  localparam int unsigned DW = 15;
  localparam int unsigned PW = 30;

  logic            ap_clk;
  logic            ap_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_lock;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [PW-1:0]   rsp_p;
  logic            busy;
`ifdef PTCALC_MUL_ARB_STATS_EN
  logic            stat_clr;
  logic [N*16-1:0] stat_grants;
`endif

  ptcalc_mul_arbiter #(.NREQ(N), .NUM_STAGE(NS), .DIN_W(DW), .DOUT_W(PW)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .busy      (busy)
`ifdef PTCALC_MUL_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int     due;
    int     idx;
    longint p;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;
  int   cyc;
  int   opa [N];
  int   opb [N];
  int   m_ptr;
  int   m_owner;
  bit   m_locked;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    opa[i] = a;
    opb[i] = b;
    req_a[i*DW +: DW] = a[DW-1:0];
    req_b[i*DW +: DW] = b[DW-1:0];
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_owner  = 0;
    m_locked = 1'b0;
    q.delete();
  endtask

  // Expected ready: owner only when locked, else first valid scanning up from the pointer.
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_locked) begin
      if (req_valid[m_owner]) r[m_owner] = 1'b1;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (r == '0 && req_valid[(m_ptr + j) % N]) r[(m_ptr + j) % N] = 1'b1;
      end
    end
    return r;
  endfunction

  // One clock cycle: check at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    logic [N-1:0] er;
    logic [N-1:0] ev;
    int g;
    @(negedge ap_clk);
    er = model_ready();
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("busy", 64'(busy), 64'(q.size() > 0 || m_locked));
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = '0;
      ev[q[0].idx] = 1'b1;
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      chk("rsp_p", 64'($signed(rsp_p)), q[0].p);
      void'(q.pop_front());
    end else begin
      chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
    end
    g = -1;
    for (int i = 0; i < N; i++) if (er[i]) g = i;
    if (g >= 0) q.push_back('{cyc + NS, g, longint'(opa[g]) * longint'(opb[g])});
    if (m_locked) begin
      if (g < 0 || !req_lock[m_owner]) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % N;
      end
    end else if (g >= 0) begin
      if (req_lock[g]) begin
        m_locked = 1'b1;
        m_owner  = g;
      end else begin
        m_ptr = (g + 1) % N;
      end
    end
    @(posedge ap_clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    req_valid = '0;
    req_lock  = '0;
    repeat (NS + 1) cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    model_reset();
    ap_rst    = 1'b1;
    req_valid = '1;
    req_lock  = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) set_op(i, 0, 0);
`ifdef PTCALC_MUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset state, with requests pending so ready gating is exercised.
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_p", 64'(rsp_p), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    req_valid = '0;
    ap_rst    = 1'b0;

    // All four valid, no lock: 0,1,2,3,0,...
    for (int i = 0; i < N; i++) set_op(i, i + 1, -(i + 2));
    req_valid = '1;
    repeat (8) cycle();
    drain();

    // Lone requester 1: -3 * 7.
    set_op(1, -3, 7);
    req_valid = 4'b0010;
    cycle();
    drain();

    // Pointer now at 2: requester 2 locks for three accepts, then releases.
    set_op(0, 100, -5);
    set_op(2, -77, 31);
    set_op(3, 1234, 2);
    req_valid = 4'b1101;
    req_lock  = 4'b0100;
    repeat (3) cycle();
    req_lock = '0;
    cycle();
    req_valid = 4'b1001;
    repeat (2) cycle();
    drain();

    // Lock released by the owner dropping valid.
    req_valid = 4'b0001;
    req_lock  = 4'b0001;
    cycle();
    req_valid = '0;
    cycle();
    req_valid = 4'b0011;
    req_lock  = '0;
    cycle();
    drain();

    // Operand extremes.
    set_op(0, -16384, 16383);
    req_valid = 4'b0001;
    cycle();
    set_op(0, -16384, -16384);
    cycle();
    set_op(0, 16383, 16383);
    cycle();
    drain();

    // Reset with two operations in flight.
    req_valid = 4'b0110;
    repeat (2) cycle();
    #2 ap_rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'(0));
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_rsp_p", 64'(rsp_p), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    model_reset();
    req_valid = '0;
    repeat (5) cycle();
    req_valid = '1;
    cycle();
    drain();

    // Random traffic.
    repeat (400) begin
      req_valid = N'($urandom);
      req_lock  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++)
        set_op(i, int'($urandom_range(0, 32767)) - 16384, int'($urandom_range(0, 32767)) - 16384);
      cycle();
    end
    drain();

`ifdef PTCALC_MUL_ARB_STATS_EN
    // Counter saturation and clear on requester 0.
    req_valid = 4'b0001;
    req_lock  = '0;
    repeat (70000) @(posedge ap_clk);
    #1;
    chk("stat_sat", 64'(stat_grants[15:0]), 64'(16'hFFFF));
    stat_clr = 1'b1;
    @(posedge ap_clk);
    #1;
    stat_clr = 1'b0;
    req_valid = '0;
    chk("stat_clr", 64'(stat_grants[15:0]), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
